// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the loadable multi-bank instruction memory.
// Build option: INST_MEM_PARITY_EN enables per-word parity storage and checking.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  localparam int DEFAULT_INSTR_W = 8;
  localparam logic [DEFAULT_INSTR_W-1:0] DEFAULT_FILL_WORD = '1;

  // Bank index width; a single bank still gets a 1-bit select.
  function automatic int bank_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Even parity: callers zero-extend, which leaves the parity unchanged.
  function automatic logic even_parity(input logic [63:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/inst_mem_bank.sv
// One program bank: synchronous write, registered read, stored program length.
// Build option: INST_MEM_PARITY_EN adds a parity bit per word and a read check.
module inst_mem_bank
  import inst_mem_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               len_clr,
  input  logic               len_set,
  input  logic [ADDR_W:0]    len_val,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data,
  output logic               rd_hit,
  output logic               rd_perr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]    len;

  // Storage array: plain RAM, never reset; the length register gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Program length: cleared when a load starts, published when it finishes.
  always_ff @(posedge clk) begin
    if (reset)        len <= '0;
    else if (len_clr) len <= '0;
    else if (len_set) len <= len_val;
  end

  // Registered read data; no reset needed because rd_hit qualifies it.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Hit flag uses the length as it stands at the sampling edge.
  always_ff @(posedge clk) begin
    if (reset)      rd_hit <= 1'b0;
    else if (rd_en) rd_hit <= ({1'b0, rd_addr} < len);
  end

`ifdef INST_MEM_PARITY_EN
  logic par [DEPTH];

  // Parity bit stored alongside each written word.
  always_ff @(posedge clk) begin
    if (wr_en) par[wr_addr] <= even_parity(64'(wr_data));
  end

  // Parity check only on hits, so unloaded words never flag.
  always_ff @(posedge clk) begin
    if (reset)      rd_perr <= 1'b0;
    else if (rd_en) rd_perr <= ({1'b0, rd_addr} < len) &&
                               (even_parity(64'(mem[rd_addr])) != par[rd_addr]);
  end
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: rtl/inst_mem_prog.sv
// Loadable multi-bank instruction memory: load FSM, bank array, fetch output mux.
// Build option: INST_MEM_PARITY_EN enables parity checking on fetch hits.
//
// state | meaning
// IDLE  | waiting for load_start_i on a valid bank
// LOAD  | accepting words on the valid/ready stream
// DONE  | one-cycle completion pulse, back to IDLE
module inst_mem_prog
  import inst_mem_pkg::*;
#(
  parameter int                 INSTR_W   = 8,
  parameter int                 ADDR_W    = 8,
  parameter int                 NUM_BANKS = 4,
  parameter logic [INSTR_W-1:0] FILL_WORD = '1,
  localparam int                BANK_W    = bank_idx_w(NUM_BANKS)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [BANK_W-1:0]  bank_sel_i,
  input  logic               fetch_req_i,
  input  logic [ADDR_W-1:0]  address_i,
  output logic [INSTR_W-1:0] instruction_o,
  output logic               instr_valid_o,
  input  logic               load_start_i,
  input  logic [BANK_W-1:0]  load_bank_i,
  input  logic [ADDR_W:0]    load_len_i,
  input  logic               load_valid_i,
  input  logic [INSTR_W-1:0] load_data_i,
  output logic               load_ready_o,
  output logic               load_busy_o,
  output logic               load_done_o,
  output logic               parity_err_o
);

  localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN   = {{ADDR_W{1'b0}}, 1'b1};

  load_state_t        state, next_state;
  logic [BANK_W-1:0]  tgt_bank;
  logic [ADDR_W:0]    tgt_len, wr_ptr, clamped_len;
  logic               start_ok, accept, last_word;

  logic               fetch_q, bank_ok_q;
  logic [BANK_W-1:0]  bank_q;
  logic [INSTR_W-1:0] hold_q, fetch_word;
  logic               sel_hit, sel_perr;

  logic [INSTR_W-1:0] rd_data [NUM_BANKS];
  logic [NUM_BANKS-1:0] rd_hit, rd_perr;

  assign clamped_len = load_len_i[ADDR_W] ? DEPTH_LEN : load_len_i;
  assign start_ok    = (state == IDLE) && load_start_i && (int'(load_bank_i) < NUM_BANKS);
  assign accept      = (state == LOAD) && load_valid_i;
  assign last_word   = (wr_ptr == tgt_len - ONE_LEN);

  // Load FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= next_state;
  end

  // Load FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = (clamped_len == '0) ? DONE : LOAD;
      LOAD:    if (accept && last_word) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Load FSM outputs.
  always_comb begin
    load_ready_o = (state == LOAD);
    load_busy_o  = (state == LOAD);
    load_done_o  = (state == DONE);
  end

  // Load target capture and write pointer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tgt_bank <= '0;
      tgt_len  <= '0;
      wr_ptr   <= '0;
    end else if (start_ok) begin
      tgt_bank <= load_bank_i;
      tgt_len  <= clamped_len;
      wr_ptr   <= '0;
    end else if (accept) begin
      wr_ptr   <= wr_ptr + ONE_LEN;
    end
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic is_tgt;
    assign is_tgt = (int'(tgt_bank) == i);

    inst_mem_bank #(
      .INSTR_W(INSTR_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk    (clk_i),
      .reset  (reset_i),
      .wr_en  (accept && is_tgt),
      .wr_addr(wr_ptr[ADDR_W-1:0]),
      .wr_data(load_data_i),
      .len_clr(start_ok && (int'(load_bank_i) == i)),
      .len_set(accept && last_word && is_tgt),
      .len_val(tgt_len),
      .rd_en  (fetch_req_i && (int'(bank_sel_i) == i)),
      .rd_addr(address_i),
      .rd_data(rd_data[i]),
      .rd_hit (rd_hit[i]),
      .rd_perr(rd_perr[i])
    );
  end

  // Remember which bank the in-flight fetch targets.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_q   <= 1'b0;
      bank_q    <= '0;
      bank_ok_q <= 1'b0;
    end else begin
      fetch_q <= fetch_req_i;
      if (fetch_req_i) begin
        bank_q    <= bank_sel_i;
        bank_ok_q <= (int'(bank_sel_i) < NUM_BANKS);
      end
    end
  end

  // Hold the last delivered word so instruction_o is stable between fetches.
  always_ff @(posedge clk_i) begin
    if (reset_i)      hold_q <= FILL_WORD;
    else if (fetch_q) hold_q <= fetch_word;
  end

  // Output mux: misses, bad banks and parity errors all read as FILL_WORD.
  always_comb begin
    sel_hit    = bank_ok_q && rd_hit[bank_q];
    sel_perr   = bank_ok_q && rd_perr[bank_q];
    fetch_word = FILL_WORD;
    if (sel_hit && !sel_perr) fetch_word = rd_data[bank_q];
    instruction_o = fetch_q ? fetch_word : hold_q;
    instr_valid_o = fetch_q;
    parity_err_o  = fetch_q && sel_perr;
  end

endmodule

// File: tb/tb_inst_mem_prog.sv
// Directed bench for inst_mem_prog: fetch vector tables plus load sequences.
module tb_inst_mem_prog;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [1:0] bank_sel_i;
  logic       fetch_req_i;
  logic [7:0] address_i;
  logic [7:0] instruction_o;
  logic       instr_valid_o;
  logic       load_start_i;
  logic [1:0] load_bank_i;
  logic [8:0] load_len_i;
  logic       load_valid_i;
  logic [7:0] load_data_i;
  logic       load_ready_o;
  logic       load_busy_o;
  logic       load_done_o;
  logic       parity_err_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] bank;
    logic [7:0] addr;
    logic [7:0] exp;
    int         phase;
  } fvec_t;

  fvec_t vecs[$];
  logic [7:0] d1 [4];

  inst_mem_prog dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .bank_sel_i   (bank_sel_i),
    .fetch_req_i  (fetch_req_i),
    .address_i    (address_i),
    .instruction_o(instruction_o),
    .instr_valid_o(instr_valid_o),
    .load_start_i (load_start_i),
    .load_bank_i  (load_bank_i),
    .load_len_i   (load_len_i),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .load_busy_o  (load_busy_o),
    .load_done_o  (load_done_o),
    .parity_err_o (parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void add(input int p, input int b, input int a, input int e);
    vecs.push_back('{bank: 2'(b), addr: 8'(a), exp: 8'(e), phase: p});
  endfunction

  task automatic fetch_chk(input fvec_t v);
    bank_sel_i  = v.bank;
    address_i   = v.addr;
    fetch_req_i = 1'b1;
    tick();
    check($sformatf("fetch_valid b%0d a%0h", v.bank, v.addr), 32'(instr_valid_o), 32'd1);
    check($sformatf("fetch_data b%0d a%0h", v.bank, v.addr), 32'(instruction_o), 32'(v.exp));
    check($sformatf("fetch_perr b%0d a%0h", v.bank, v.addr), 32'(parity_err_o), 32'd0);
    fetch_req_i = 1'b0;
    tick();
    check($sformatf("idle_valid b%0d a%0h", v.bank, v.addr), 32'(instr_valid_o), 32'd0);
    check($sformatf("hold_data b%0d a%0h", v.bank, v.addr), 32'(instruction_o), 32'(v.exp));
  endtask

  task automatic run_phase(input int p);
    foreach (vecs[i]) if (vecs[i].phase == p) fetch_chk(vecs[i]);
  endtask

  initial begin
    int cnt;
    int ready_cnt;
    int done_cnt;
    logic acc;

    d1 = '{8'hC0, 8'hC2, 8'hC3, 8'h11};
    add(0, 0, 8'h00, 8'hFF); add(0, 3, 8'hFF, 8'hFF);
    add(1, 1, 0, 8'hC0); add(1, 1, 1, 8'hC2); add(1, 1, 2, 8'hC3);
    add(1, 1, 3, 8'h11); add(1, 1, 4, 8'hFF); add(1, 0, 0, 8'hFF);
    add(2, 2, 0, 8'hD0); add(2, 2, 1, 8'hD1); add(2, 2, 2, 8'hD2);
    add(2, 2, 3, 8'hFF); add(2, 1, 2, 8'hC3);
    add(3, 0, 8'h00, 8'h5A); add(3, 0, 8'hFF, 8'hA5); add(3, 0, 8'h80, 8'hDA);
    add(3, 1, 8'h00, 8'hC0); add(3, 3, 8'h00, 8'hFF);
    add(4, 2, 0, 8'hFF); add(4, 1, 1, 8'hC2);
    add(5, 0, 0, 8'hFF); add(5, 1, 0, 8'hFF); add(5, 2, 0, 8'hFF); add(5, 3, 0, 8'hFF);

    reset_i = 1'b1; bank_sel_i = '0; fetch_req_i = 1'b0; address_i = '0;
    load_start_i = 1'b0; load_bank_i = '0; load_len_i = '0;
    load_valid_i = 1'b0; load_data_i = '0;
    repeat (3) tick();
    check("reset_instr", 32'(instruction_o), 32'hFF);
    check("reset_valid", 32'(instr_valid_o), 32'd0);
    check("reset_ready", 32'(load_ready_o), 32'd0);
    check("reset_busy", 32'(load_busy_o), 32'd0);
    check("reset_done", 32'(load_done_o), 32'd0);
    check("reset_perr", 32'(parity_err_o), 32'd0);
    reset_i = 1'b0;
    tick();
    run_phase(0);

    // Bank 1, four words, no stalls.
    load_start_i = 1'b1; load_bank_i = 2'd1; load_len_i = 9'd4;
    tick();
    load_start_i = 1'b0;
    check("b1_busy", 32'(load_busy_o), 32'd1);
    check("b1_ready", 32'(load_ready_o), 32'd1);
    ready_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      load_valid_i = 1'b1; load_data_i = d1[i];
      if (load_ready_o) ready_cnt++;
      tick();
      if (load_done_o) done_cnt++;
    end
    load_valid_i = 1'b0;
    check("b1_done_now", 32'(load_done_o), 32'd1);
    check("b1_busy_in_done", 32'(load_busy_o), 32'd0);
    tick();
    if (load_done_o) done_cnt++;
    if (load_ready_o) ready_cnt++;
    check("b1_ready_cycles", 32'(ready_cnt), 32'd4);
    check("b1_done_pulses", 32'(done_cnt), 32'd1);
    run_phase(1);

    // Bank 2, three words with a stalling stream, fetching concurrently.
    load_start_i = 1'b1; load_bank_i = 2'd2; load_len_i = 9'd3;
    tick();
    load_start_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      fetch_req_i  = 1'b1;
      bank_sel_i   = (k >= 5) ? 2'd2 : 2'd1;
      address_i    = (k >= 5) ? 8'h00 : 8'h02;
      load_valid_i = (k % 2 == 1);
      load_data_i  = 8'hD0 + 8'(cnt);
      acc = load_valid_i && load_ready_o;
      tick();
      if (acc) cnt++;
      check($sformatf("b2_cc_valid k%0d", k), 32'(instr_valid_o), 32'd1);
      if (k < 5) begin
        check($sformatf("b2_cc_b1 k%0d", k), 32'(instruction_o), 32'hC3);
        check($sformatf("b2_cc_ready k%0d", k), 32'(load_ready_o), 32'd1);
      end else if (k == 5) begin
        check("b2_final_write_fetch", 32'(instruction_o), 32'hFF);
        check("b2_done", 32'(load_done_o), 32'd1);
      end else begin
        check("b2_after_final_fetch", 32'(instruction_o), 32'hD0);
        check("b2_done_cleared", 32'(load_done_o), 32'd0);
      end
    end
    fetch_req_i = 1'b0; load_valid_i = 1'b0;
    tick();
    check("b2_words_accepted", 32'(cnt), 32'd3);
    run_phase(2);

    // Oversized length clamps to 256; a second start while busy is ignored.
    load_start_i = 1'b1; load_bank_i = 2'd0; load_len_i = 9'h1FF;
    tick();
    load_start_i = 1'b0;
    cnt = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      load_valid_i = 1'b1;
      load_data_i  = 8'(cnt) ^ 8'h5A;
      load_start_i = (cnt == 10);
      load_bank_i  = (cnt == 10) ? 2'd1 : 2'd0;
      load_len_i   = (cnt == 10) ? 9'd2 : 9'h1FF;
      acc = load_ready_o;
      tick();
      load_start_i = 1'b0;
      if (acc) cnt++;
      if (load_done_o) begin
        done_cnt++;
        break;
      end
    end
    load_valid_i = 1'b0;
    check("clamp_accepted", 32'(cnt), 32'd256);
    check("clamp_done_seen", 32'(done_cnt), 32'd1);
    tick();
    check("clamp_done_single", 32'(load_done_o), 32'd0);
    check("clamp_idle_busy", 32'(load_busy_o), 32'd0);
    run_phase(3);

`ifdef INST_MEM_PARITY_EN
    dut.g_bank[1].u_bank.mem[0] = 8'hC1;
    bank_sel_i = 2'd1; address_i = 8'h00; fetch_req_i = 1'b1;
    tick();
    check("par_flip_perr", 32'(parity_err_o), 32'd1);
    check("par_flip_data", 32'(instruction_o), 32'hFF);
    check("par_flip_valid", 32'(instr_valid_o), 32'd1);
    address_i = 8'h01;
    tick();
    check("par_ok_perr", 32'(parity_err_o), 32'd0);
    check("par_ok_data", 32'(instruction_o), 32'hC2);
    fetch_req_i = 1'b0;
    tick();
`endif

    // Zero-length load on the loaded bank 2.
    load_start_i = 1'b1; load_bank_i = 2'd2; load_len_i = 9'd0;
    tick();
    load_start_i = 1'b0;
    check("len0_done", 32'(load_done_o), 32'd1);
    check("len0_busy", 32'(load_busy_o), 32'd0);
    check("len0_ready", 32'(load_ready_o), 32'd0);
    tick();
    check("len0_done_single", 32'(load_done_o), 32'd0);
    run_phase(4);

    // Reset after two of four words.
    load_start_i = 1'b1; load_bank_i = 2'd3; load_len_i = 9'd4;
    tick();
    load_start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid_i = 1'b1; load_data_i = 8'hE0 + 8'(i);
      tick();
    end
    load_valid_i = 1'b0;
    check("mid_busy_before_reset", 32'(load_busy_o), 32'd1);
    reset_i = 1'b1;
    tick();
    check("mid_reset_busy", 32'(load_busy_o), 32'd0);
    check("mid_reset_done", 32'(load_done_o), 32'd0);
    check("mid_reset_ready", 32'(load_ready_o), 32'd0);
    reset_i = 1'b0;
    tick();
    check("mid_after_done", 32'(load_done_o), 32'd0);
    check("mid_after_busy", 32'(load_busy_o), 32'd0);
    check("mid_after_instr", 32'(instruction_o), 32'hFF);
    run_phase(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_prog.md
Name: inst_mem_prog

Overview:
Parametrised, loadable, multi-bank instruction memory that replaces the fixed combinational program ROM.
- Holds NUM_BANKS independent programs; the core selects one bank and fetches with a registered 1-cycle read.
- A streaming load port (valid/ready) fills any bank at runtime.
- Unloaded or out-of-range addresses return FILL_WORD (the halt/invalid encoding), matching the old default.

Parameters:
INSTR_W, 8, instruction word width
ADDR_W, 8, per-bank address width; depth 2**ADDR_W words
NUM_BANKS, 4, number of program banks (>=1)
FILL_WORD, all ones, word returned for unloaded or out-of-range fetches

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
bank_sel_i  in  max(1,$clog2(NUM_BANKS))  bank for fetch
fetch_req_i  in  1  fetch strobe
address_i  in  ADDR_W  fetch address
instruction_o  out  INSTR_W  fetched word
instr_valid_o  out  1  instruction_o valid this cycle
load_start_i  in  1  begin loading a bank
load_bank_i  in  max(1,$clog2(NUM_BANKS))  target bank
load_len_i  in  ADDR_W+1  number of words to load
load_valid_i  in  1  load word valid
load_data_i  in  INSTR_W  load word
load_ready_o  out  1  load word accepted when valid&ready
load_busy_o  out  1  load in progress
load_done_o  out  1  one-cycle pulse when load completes
parity_err_o  out  1  parity mismatch on fetch (see Optional Feature)

Behaviour:
Reset values:
- instruction_o=FILL_WORD; instr_valid_o=0; load_ready_o=0; load_busy_o=0; load_done_o=0; parity_err_o=0.
- All bank lengths = 0. Memory contents are not cleared but are unreachable.

Fetch:
- fetch_req_i sampled at edge N together with bank_sel_i and address_i.
- At N+1: instr_valid_o=1 for one cycle; instruction_o = mem[bank][addr] if addr < len[bank], else FILL_WORD.
- Without a request: instr_valid_o=0 and instruction_o holds its last value.
- Back-to-back requests give one result per cycle.
- bank_sel_i >= NUM_BANKS returns FILL_WORD.

Load FSM (IDLE, LOAD, DONE):
- IDLE: load_start_i captures load_bank_i and min(load_len_i, 2**ADDR_W), clears len[bank] to 0, and zeroes the write pointer.
  - Captured length 0: go to DONE.
  - Otherwise: go to LOAD.
- LOAD:
  - load_ready_o=1 and load_busy_o=1.
  - Each valid&ready writes load_data_i at the write pointer, then increments the pointer.
  - Acceptance of the last word sets len[bank] = captured length; go to DONE.
  - load_valid_i low stalls indefinitely.
- DONE: load_done_o=1 for exactly one cycle, load_busy_o=0; return to IDLE.
- load_start_i outside IDLE is ignored.
- load_bank_i >= NUM_BANKS is ignored; FSM stays in IDLE.

Concurrency:
- During LOAD, fetches to the bank being loaded return FILL_WORD, since its length is 0.
- Fetches to other banks proceed normally.
- A fetch in the cycle the final word is written still sees the old length (0); the next cycle sees the new length.

Reset mid-load: FSM returns to IDLE, all lengths return to 0, and load_done_o is not pulsed.

Optional Feature:
Macro INST_MEM_PARITY_EN.
- With it: each stored word carries an even-parity bit computed on write. On a fetch hit, a mismatch sets parity_err_o=1 alongside instr_valid_o and forces instruction_o=FILL_WORD. Out-of-range fetches never flag.
- Without it: no parity storage and parity_err_o is tied to 0.

Decomposition:
- Package inst_mem_pkg: load_state_t enum (IDLE/LOAD/DONE), default FILL_WORD constant, parity function, and the bank-index width helper.
- Sub-module inst_mem_bank: one synchronous RAM bank with one write port, one registered read port and a stored length register; instantiated NUM_BANKS times. The top level holds the load FSM and the output mux.

Test Plan:
- Reset, then fetch bank 0 addr 0x00 and bank 3 addr 0xFF -> instr_valid_o pulses 1 cycle later; instruction_o=0xFF for both.
- Load bank 1, len 4, data C0,C2,C3,11 with no stalls -> load_ready_o high 4 cycles, load_done_o single pulse; fetch addr 0..4 -> C0,C2,C3,11,FF.
- Load bank 2, len 3 with load_valid_i toggling every other cycle, while fetching bank 1 addr 2 every cycle -> bank 1 returns C3 throughout; bank 2 reads FF until the cycle after the final write, then returns the loaded data.
- load_len_i=0x1FF -> clamped to 256 and accepts exactly 256 words. Second load_start_i while busy -> ignored. load_len_i=0 -> load_done_o the cycle after start, bank reads FF.
- Assert reset_i after 2 of 4 words accepted -> load_busy_o=0, no load_done_o; all banks read FF, including a previously loaded bank 1.
- With INST_MEM_PARITY_EN, force a stored bit flip in bank 1 addr 0 and fetch it -> parity_err_o=1, instruction_o=FF; an unflipped addr 1 -> parity_err_o=0, instruction_o=C2.
